// File: rtl/intersection_arbiter_pkg.sv
// Shared types and constants for the intersection arbiter: phase codes,
// lamp encodings, default timing and the round-robin pick helper.
package intersection_arbiter_pkg;

  typedef enum logic [2:0] {
    GREEN_N  = 3'd0,
    YELLOW_N = 3'd1,
    GREEN_E  = 3'd2,
    YELLOW_E = 3'd3,
    ALL_RED  = 3'd4,
    WALK_P   = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    SRV_N = 2'd0,
    SRV_E = 2'd1,
    SRV_P = 2'd2
  } served_e;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  localparam int DEF_CNT_MAX     = 50_000_000;
  localparam int DEF_T_MIN_GREEN = 10;
  localparam int DEF_T_MAX_GREEN = 30;
  localparam int DEF_T_YELLOW    = 3;
  localparam int DEF_T_ALLRED    = 1;
  localparam int DEF_T_WALK      = 8;

  // pend[0]=North, pend[1]=East, pend[2]=pedestrian; search starts after last.
  function automatic phase_e rr_pick(input served_e last, input logic [2:0] pend);
    phase_e pick;
    pick = GREEN_N;
    unique case (last)
      SRV_N:   pick = pend[1] ? GREEN_E : (pend[2] ? WALK_P : GREEN_N);
      SRV_E:   pick = pend[2] ? WALK_P : (pend[0] ? GREEN_N : (pend[1] ? GREEN_E : GREEN_N));
      SRV_P:   pick = pend[0] ? GREEN_N : (pend[1] ? GREEN_E : (pend[2] ? WALK_P : GREEN_N));
      default: pick = GREEN_N;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/intersection_arbiter_if.sv
// Request and lamp bundle between the intersection arbiter and its environment.
interface intersection_arbiter_if;
  logic [2:0]                      REQ;
  logic [2:0]                      LED_N;
  logic [2:0]                      LED_E;
  logic                            WALK;
  intersection_arbiter_pkg::phase_e PHASE;
  logic [5:0]                      SEC_LEFT;

  modport master (output REQ, input LED_N, LED_E, WALK, PHASE, SEC_LEFT);
  modport slave  (input REQ, output LED_N, LED_E, WALK, PHASE, SEC_LEFT);
endinterface

// File: rtl/sec_tick.sv
// Free-running divider producing a one-clock pulse every CNT_MAX clocks;
// the first pulse ends exactly CNT_MAX clocks after reset release.
module sec_tick #(
  parameter int CNT_MAX = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [W-1:0] LAST = W'(CNT_MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/intersection_arbiter.sv
// Two-road traffic light with pedestrian phase: tick-paced phase FSM with
// min/max green, yellow, all-red clearance and round-robin service.
module intersection_arbiter
  import intersection_arbiter_pkg::*;
#(
  parameter int CNT_MAX     = DEF_CNT_MAX,
  parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
  parameter int T_MAX_GREEN = DEF_T_MAX_GREEN,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int T_WALK      = DEF_T_WALK
) (
  input logic                   CLOCK_50,
  input logic                   RESET,
  intersection_arbiter_if.slave bus
);

  generate
    if (!(CNT_MAX >= 1 && T_MIN_GREEN >= 1 && T_MIN_GREEN <= T_MAX_GREEN &&
          T_MAX_GREEN <= 63 && T_YELLOW >= 1 && T_YELLOW <= 63 &&
          T_ALLRED >= 1 && T_ALLRED <= 63 && T_WALK >= 1 && T_WALK <= 63)) begin : g_bad_params
      $error("intersection_arbiter: illegal timing parameters");
    end
  endgenerate

  localparam logic [5:0] MIN6  = 6'(T_MIN_GREEN);
  localparam logic [5:0] MAX6  = 6'(T_MAX_GREEN);
  localparam logic [5:0] YEL6  = 6'(T_YELLOW);
  localparam logic [5:0] AR6   = 6'(T_ALLRED);
  localparam logic [5:0] WALK6 = 6'(T_WALK);

  logic tick;

  sec_tick #(.CNT_MAX(CNT_MAX)) u_sec_tick (
    .clk  (CLOCK_50),
    .rst  (RESET),
    .tick (tick)
  );

  phase_e     state_q, state_d;
  served_e    last_q, last_d;
  logic [5:0] elapsed_q, elapsed_d;
  logic       ped_q, ped_d;
  logic [2:0] led_n_q, led_n_d, led_e_q, led_e_d;
  logic       walk_q, walk_d;
  logic [5:0] sec_q, sec_d;

  logic [5:0] el_now;
  logic [5:0] base;
  logic       n_comp, e_comp;

  // Transition tests use the elapsed count including the current tick.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    elapsed_d = elapsed_q;
    ped_d     = ped_q | bus.REQ[2];
    el_now    = (elapsed_q == 6'd63) ? 6'd63 : elapsed_q + 6'd1;
    n_comp    = bus.REQ[1] | ped_q;
    e_comp    = bus.REQ[0] | ped_q;

    if (tick) begin
      unique case (state_q)
        GREEN_N:
          if (n_comp && ((el_now >= MAX6) || ((el_now >= MIN6) && !bus.REQ[0])))
            state_d = YELLOW_N;
        GREEN_E:
          if (e_comp && ((el_now >= MAX6) || ((el_now >= MIN6) && !bus.REQ[1])))
            state_d = YELLOW_E;
        YELLOW_N, YELLOW_E:
          if (el_now >= YEL6) state_d = ALL_RED;
        WALK_P:
          if (el_now >= WALK6) state_d = ALL_RED;
        ALL_RED:
          if (el_now >= AR6) state_d = rr_pick(last_q, {ped_q, bus.REQ[1], bus.REQ[0]});
        default:
          state_d = GREEN_N;
      endcase

      elapsed_d = (state_d != state_q) ? 6'd0 : el_now;

      if (state_d != state_q) begin
        unique case (state_d)
          GREEN_N: last_d = SRV_N;
          GREEN_E: last_d = SRV_E;
          WALK_P: begin
            last_d = SRV_P;
            ped_d  = 1'b0;
          end
          default: last_d = last_q;
        endcase
      end
    end
  end

  always_comb begin
    led_n_d = LIGHT_RED;
    led_e_d = LIGHT_RED;
    walk_d  = 1'b0;
    base    = MIN6;
    unique case (state_d)
      GREEN_N:  led_n_d = LIGHT_GREEN;
      YELLOW_N: begin led_n_d = LIGHT_YELLOW; base = YEL6; end
      GREEN_E:  led_e_d = LIGHT_GREEN;
      YELLOW_E: begin led_e_d = LIGHT_YELLOW; base = YEL6; end
      ALL_RED:  base = AR6;
      WALK_P:   begin walk_d = 1'b1; base = WALK6; end
      default:  base = MIN6;
    endcase
    sec_d = (elapsed_d >= base) ? 6'd0 : base - elapsed_d;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= GREEN_N;
      last_q    <= SRV_N;
      elapsed_q <= 6'd0;
      ped_q     <= 1'b0;
      led_n_q   <= LIGHT_GREEN;
      led_e_q   <= LIGHT_RED;
      walk_q    <= 1'b0;
      sec_q     <= MIN6;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      elapsed_q <= elapsed_d;
      ped_q     <= ped_d;
      led_n_q   <= led_n_d;
      led_e_q   <= led_e_d;
      walk_q    <= walk_d;
      sec_q     <= sec_d;
    end
  end

  assign bus.LED_N    = led_n_q;
  assign bus.LED_E    = led_e_q;
  assign bus.WALK     = walk_q;
  assign bus.PHASE    = state_q;
  assign bus.SEC_LEFT = sec_q;

endmodule

// File: tb/tb_intersection_arbiter.sv
// Bench for intersection_arbiter at CNT_MAX=5: vector table, hand-written
// corner sequences and a random run checked against a per-second model.
module tb_intersection_arbiter;
  import intersection_arbiter_pkg::*;

  localparam int CNT  = 5;
  localparam int TMIN = DEF_T_MIN_GREEN;
  localparam int TMAX = DEF_T_MAX_GREEN;
  localparam int TYEL = DEF_T_YELLOW;
  localparam int TAR  = DEF_T_ALLRED;
  localparam int TWLK = DEF_T_WALK;

  logic CLOCK_50;
  logic RESET;
  intersection_arbiter_if bus();

  intersection_arbiter #(
    .CNT_MAX(CNT), .T_MIN_GREEN(TMIN), .T_MAX_GREEN(TMAX),
    .T_YELLOW(TYEL), .T_ALLRED(TAR), .T_WALK(TWLK)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase, seconds spent in it, ped latch, last served road.
  phase_e m_ph;
  int     m_el;
  bit     m_ped;
  int     m_last;   // 0 North, 1 East, 2 pedestrian
  int     cyc;

  function automatic int dur_of(input phase_e p);
    case (p)
      YELLOW_N, YELLOW_E: return TYEL;
      ALL_RED:            return TAR;
      WALK_P:             return TWLK;
      default:            return TMIN;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = GREEN_N; m_el = 0; m_ped = 0; m_last = 0; cyc = 0;
  endtask

  task automatic model_edge(input logic [2:0] r);
    int     secs;
    phase_e nxt;
    bit     own, other, ped_next;
    bit     pend [3];
    phase_e serve [3];
    cyc++;
    ped_next = m_ped | r[2];
    if (cyc % CNT == 0) begin
      secs = (m_el < 63) ? m_el + 1 : 63;
      nxt  = m_ph;
      case (m_ph)
        GREEN_N, GREEN_E: begin
          own   = (m_ph == GREEN_N) ? r[0] : r[1];
          other = (m_ph == GREEN_N) ? r[1] : r[0];
          if ((other || m_ped) && (secs >= TMAX || (secs >= TMIN && !own)))
            nxt = (m_ph == GREEN_N) ? YELLOW_N : YELLOW_E;
        end
        ALL_RED: if (secs >= TAR) begin
          pend[0] = r[0]; pend[1] = r[1]; pend[2] = m_ped;
          serve[0] = GREEN_N; serve[1] = GREEN_E; serve[2] = WALK_P;
          nxt = GREEN_N;
          for (int k = 3; k >= 1; k--)
            if (pend[(m_last + k) % 3]) nxt = serve[(m_last + k) % 3];
        end
        default: if (secs >= dur_of(m_ph)) nxt = ALL_RED;
      endcase
      if (nxt != m_ph) begin
        m_el = 0;
        if (nxt == GREEN_N) m_last = 0;
        if (nxt == GREEN_E) m_last = 1;
        if (nxt == WALK_P) begin m_last = 2; ped_next = 0; end
      end else begin
        m_el = secs;
      end
      m_ph = nxt;
    end
    m_ped = ped_next;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [2:0] en, ee;
    int base, sec;
    en = 3'b100; ee = 3'b100;
    case (m_ph)
      GREEN_N:  en = 3'b001;
      YELLOW_N: en = 3'b010;
      GREEN_E:  ee = 3'b001;
      YELLOW_E: ee = 3'b010;
      default:  ;
    endcase
    base = dur_of(m_ph);
    sec  = (base > m_el) ? base - m_el : 0;
    n_cmp++;
    if (bus.LED_N !== en || bus.LED_E !== ee || bus.WALK !== (m_ph == WALK_P) ||
        bus.PHASE !== m_ph || bus.SEC_LEFT !== 6'(sec)) begin
      n_bad++;
      $display("FAIL model cyc=%0d: got N=%b E=%b W=%b ph=%0d sec=%0d expected N=%b E=%b W=%b ph=%0d sec=%0d",
               cyc, bus.LED_N, bus.LED_E, bus.WALK, bus.PHASE, bus.SEC_LEFT,
               en, ee, (m_ph == WALK_P), m_ph, sec);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic clk_step(input logic [2:0] r);
    bus.REQ = r;
    @(posedge CLOCK_50);
    model_edge(r);
    #1;
    check_model();
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    RESET   = 1'b1;
    bus.REQ = 3'b000;
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
    model_reset();
  endtask

  typedef struct {
    string      name;
    bit         rst;
    logic [2:0] req;
    int         ticks;
    phase_e     ph;
    logic [2:0] ln;
    logic [2:0] le;
    logic       walk;
    logic [5:0] sec;
  } vec_t;

  vec_t        vecs [14];
  phase_e      seen [$];
  phase_e      exp_seq [8];
  phase_e      prev;
  logic [2:0]  r;
  int          walk_clk;
  int          hold;

  initial begin
    RESET   = 1'b1;
    bus.REQ = 3'b000;

    // Rows run cumulatively from the previous row; tick k lands on clock 5k.
    vecs[0]  = '{"idle_t5",      1'b1, 3'b000,  5, GREEN_N,  3'b001, 3'b100, 1'b0, 6'd5};
    vecs[1]  = '{"idle_t10",     1'b0, 3'b000,  5, GREEN_N,  3'b001, 3'b100, 1'b0, 6'd0};
    vecs[2]  = '{"idle_t100",    1'b0, 3'b000, 90, GREEN_N,  3'b001, 3'b100, 1'b0, 6'd0};
    vecs[3]  = '{"east_t9",      1'b1, 3'b010,  9, GREEN_N,  3'b001, 3'b100, 1'b0, 6'd1};
    vecs[4]  = '{"east_t10",     1'b0, 3'b010,  1, YELLOW_N, 3'b010, 3'b100, 1'b0, 6'd3};
    vecs[5]  = '{"east_t13",     1'b0, 3'b010,  3, ALL_RED,  3'b100, 3'b100, 1'b0, 6'd1};
    vecs[6]  = '{"east_t14",     1'b0, 3'b010,  1, GREEN_E,  3'b100, 3'b001, 1'b0, 6'd10};
    vecs[7]  = '{"east_hold",    1'b0, 3'b000, 50, GREEN_E,  3'b100, 3'b001, 1'b0, 6'd0};
    vecs[8]  = '{"both_t29",     1'b1, 3'b011, 29, GREEN_N,  3'b001, 3'b100, 1'b0, 6'd0};
    vecs[9]  = '{"both_t30",     1'b0, 3'b011,  1, YELLOW_N, 3'b010, 3'b100, 1'b0, 6'd3};
    vecs[10] = '{"both_t34",     1'b0, 3'b011,  4, GREEN_E,  3'b100, 3'b001, 1'b0, 6'd10};
    vecs[11] = '{"both_t63",     1'b0, 3'b011, 29, GREEN_E,  3'b100, 3'b001, 1'b0, 6'd0};
    vecs[12] = '{"both_t64",     1'b0, 3'b011,  1, YELLOW_E, 3'b100, 3'b010, 1'b0, 6'd3};
    vecs[13] = '{"both_t68",     1'b0, 3'b011,  4, GREEN_N,  3'b001, 3'b100, 1'b0, 6'd10};

    do_reset();
    chk("reset_led_n", bus.LED_N, 3'b001);
    chk("reset_led_e", bus.LED_E, 3'b100);
    chk("reset_walk",  bus.WALK, 1'b0);
    chk("reset_sec",   bus.SEC_LEFT, 6'(TMIN));

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      repeat (vecs[i].ticks * CNT) clk_step(vecs[i].req);
      chk({vecs[i].name, "_phase"}, bus.PHASE, vecs[i].ph);
      chk({vecs[i].name, "_led_n"}, bus.LED_N, vecs[i].ln);
      chk({vecs[i].name, "_led_e"}, bus.LED_E, vecs[i].le);
      chk({vecs[i].name, "_walk"},  bus.WALK, vecs[i].walk);
      chk({vecs[i].name, "_sec"},   bus.SEC_LEFT, vecs[i].sec);
      $display("vector %0d %s req=%b ph=%0d N=%b E=%b sec=%0d", i, vecs[i].name,
               vecs[i].req, bus.PHASE, bus.LED_N, bus.LED_E, bus.SEC_LEFT);
    end

    // Pedestrian press during a contested North green. East drops during the
    // walk so the following all-red finds nothing pending and returns North.
    do_reset();
    prev = GREEN_N; walk_clk = 0;
    for (int c = 1; c <= 300; c++) begin
      r = (c <= 250) ? 3'b010 : 3'b000;
      if (c == 16) r[2] = 1'b1;
      clk_step(r);
      if (bus.WALK === 1'b1) walk_clk++;
      if (bus.PHASE !== prev) begin
        seen.push_back(bus.PHASE);
        prev = bus.PHASE;
      end
    end
    exp_seq = '{YELLOW_N, ALL_RED, GREEN_E, YELLOW_E, ALL_RED, WALK_P, ALL_RED, GREEN_N};
    chk("ped_seq_len", seen.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("ped_seq_%0d", i), (i < seen.size()) ? 32'(seen[i]) : 32'd7, exp_seq[i]);
    chk("ped_walk_clocks", walk_clk, TWLK * CNT);
    $display("ped sequence: %0d phase changes, walk lamp %0d clocks", seen.size(), walk_clk);

    // One-clock asynchronous reset in the middle of East yellow.
    do_reset();
    for (int c = 1; c <= 327; c++) clk_step((c == 200) ? 3'b111 : 3'b011);
    chk("mid_yellow_e_phase", bus.PHASE, YELLOW_E);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_led_n", bus.LED_N, 3'b001);
    chk("async_rst_led_e", bus.LED_E, 3'b100);
    chk("async_rst_phase", bus.PHASE, GREEN_N);
    chk("async_rst_walk",  bus.WALK, 1'b0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    model_reset();
    repeat (4) clk_step(3'b000);
    chk("rst_pre_tick_sec", bus.SEC_LEFT, 6'(TMIN));
    clk_step(3'b000);
    chk("rst_first_tick_sec", bus.SEC_LEFT, 6'(TMIN - 1));
    repeat (12 * CNT) clk_step(3'b000);
    chk("rst_ped_cleared", bus.PHASE, GREEN_N);
    $display("async reset: phase=%0d sec=%0d after 13 ticks idle", bus.PHASE, bus.SEC_LEFT);

    // Random request levels held for random spans, occasional ped presses.
    do_reset();
    for (int blk = 0; blk < 80; blk++) begin
      r = 3'($urandom_range(0, 3));
      hold = $urandom_range(1, 60);
      for (int h = 0; h < hold; h++)
        clk_step({($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, r[1:0]});
    end
    $display("random run done at model cycle %0d, phase=%0d", cyc, m_ph);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intersection_arbiter.md
INTERSECTION_ARBITER -- requirements
Module: intersection_arbiter

Interface
REQ-001 Parameter CNT_MAX, default 50_000_000, clocks per one-second tick.
REQ-002 Parameter T_MIN_GREEN, default 10, minimum green seconds; T_MAX_GREEN, default 30, maximum green seconds when another request waits.
REQ-003 Parameter T_YELLOW, default 3; T_ALLRED, default 1; T_WALK, default 8; all in seconds.
REQ-004 CLOCK_50  input  1  sole clock, rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 REQ  input  3  level requests: bit0 North car, bit1 East car, bit2 pedestrian button.
REQ-007 LED_N  output  3  North light, one-hot: 001 green, 010 yellow, 100 red.
REQ-008 LED_E  output  3  East light, same encoding.
REQ-009 WALK  output  1  pedestrian walk lamp.
REQ-010 PHASE  output  3  current state code (package enum).
REQ-011 SEC_LEFT  output  6  remaining seconds of the current timed interval.

Function
REQ-012 Timing is in ticks; a tick asserts for one clock every CNT_MAX clocks; all state and timer changes occur only on tick clocks.
REQ-013 States: GREEN_N, YELLOW_N, GREEN_E, YELLOW_E, ALL_RED, WALK_P.
REQ-014 Lights per state: GREEN_x drives x 001 and the other road 100; YELLOW_x drives x 010 and the other road 100; ALL_RED and WALK_P drive both roads 100; WALK=1 only in WALK_P.
REQ-015 A 6-bit elapsed-seconds counter clears on every state entry, increments per tick, and saturates at 63.
REQ-016 Pedestrian REQ[2] is latched sticky on any clock; the latch clears on WALK_P entry; a press during WALK_P re-latches.
REQ-017 "Competing request" in GREEN_N = REQ[1] or the ped latch; in GREEN_E = REQ[0] or the ped latch.
REQ-018 GREEN_x holds indefinitely with no competing request.
REQ-019 GREEN_x -> YELLOW_x on the tick where elapsed >= T_MIN_GREEN, a competing request exists, and the own-road REQ bit is 0.
REQ-020 GREEN_x -> YELLOW_x on the tick where elapsed >= T_MAX_GREEN and a competing request exists, regardless of the own-road REQ bit.
REQ-021 YELLOW_x -> ALL_RED after T_YELLOW ticks; WALK_P -> ALL_RED after T_WALK ticks.
REQ-022 ALL_RED exits after T_ALLRED ticks to the first pending requester in round-robin order N->E->P, starting after the last served phase.
REQ-023 If nothing is pending at ALL_RED exit, the next state is GREEN_N.
REQ-024 The last-served pointer updates on entry to GREEN_N, GREEN_E or WALK_P.
REQ-025 SEC_LEFT in YELLOW/ALL_RED/WALK_P = duration - elapsed; in GREEN = T_MIN_GREEN - elapsed, floored at 0.
REQ-026 REQ changes between ticks affect only the next tick decision; there is no internal request buffering except the ped latch.

Reset
REQ-027 RESET=1 asynchronously forces GREEN_N, elapsed=0, tick counter=0, ped latch=0, last-served=N.
REQ-028 Output reset values: LED_N=001, LED_E=100, WALK=0, SEC_LEFT=T_MIN_GREEN.
REQ-029 Reset asserted mid-interval, including YELLOW or WALK_P, abandons the interval with no completion.
REQ-030 The first tick occurs CNT_MAX clocks after RESET deasserts.

Structure
REQ-031 A shared package holds the state enum, the light encodings (GREEN/YELLOW/RED), and the default timing constants.
REQ-032 One sub-module, sec_tick, is parameterised by CNT_MAX and produces the one-clock tick pulse; it is the only divider.
REQ-033 T_MIN_GREEN <= T_MAX_GREEN <= 63, and all durations >= 1; an elaboration check rejects violations.

Verification (CNT_MAX=5)
REQ-034 Reset release with REQ=000 for 100 ticks -> LED_N=001 and LED_E=100 throughout, SEC_LEFT reaching 0 after tick 10.
REQ-035 REQ=010 from reset -> YELLOW_N at tick 10, ALL_RED at tick 13, GREEN_E at tick 14 (LED_E=001); the block stays in GREEN_E after REQ drops.
REQ-036 REQ=011 held -> green alternates N/E, each lasting exactly 30 ticks, separated by 3 yellow ticks and 1 all-red tick.
REQ-037 In GREEN_N with REQ=010 held, a one-clock REQ[2] pulse -> order is GREEN_E, then WALK_P (WALK=1 for 8 ticks), then GREEN_N.
REQ-038 RESET pulsed for 1 clock mid-YELLOW_E -> LED_N=001 and LED_E=100 in the same cycle, the ped latch is cleared, and the next tick arrives 5 clocks after release.
